// File: rtl/uart_tx_pkg.sv
// Shared UART transmit definitions: controller state encoding, line-mux selects
// and the default frame width, used by the controller and the line mux.
package uart_tx_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_STOP  = 2'b01;
  localparam logic [1:0] MUX_DATA  = 2'b10;
  localparam logic [1:0] MUX_PAR   = 2'b11;

  // Any encoding outside the legal set drives the idle-high level.
  function automatic logic [1:0] state_mux_sel(input tx_state_e s);
    logic [1:0] sel;
    sel = MUX_STOP;
    case (s)
      ST_START:  sel = MUX_START;
      ST_DATA:   sel = MUX_DATA;
      ST_PARITY: sel = MUX_PAR;
      default:   sel = MUX_STOP;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: sequences start, data, optional parity and stop bits.
// Define UART_TX_STOP2_EN to stretch the stop bit to two cycles.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  output logic       ser_load,
  output logic       ser_shift,
  output logic [1:0] mux_sel,
  output logic       busy,
  output tx_state_e  dbg_state
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_en_q, par_en_d;
  logic             busy_q;
`ifdef UART_TX_STOP2_EN
  logic             stop_cnt_q, stop_cnt_d;
`endif

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      par_en_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      par_en_q <= par_en_d;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

`ifdef UART_TX_STOP2_EN
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) stop_cnt_q <= 1'b0;
    else      stop_cnt_q <= stop_cnt_d;
  end
`endif

  // Handshake: Data_Valid is a request; it is taken only in IDLE, where ser_load
  // echoes it combinationally as the acceptance strobe. Requests while busy are dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    par_en_d  = par_en_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
`ifdef UART_TX_STOP2_EN
    stop_cnt_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        ser_load = Data_Valid & RST;
        if (Data_Valid) begin
          state_d  = ST_START;
          par_en_d = PAR_EN;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        ser_shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP: begin
`ifdef UART_TX_STOP2_EN
        if (stop_cnt_q) state_d = ST_IDLE;
        else            stop_cnt_d = 1'b1;
`else
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        par_en_d = 1'b0;
      end
    endcase
  end

  assign mux_sel   = state_mux_sel(state_q);
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: per-cycle expected output vectors are queued
// when a request is driven and popped at each negative clock edge.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       RST;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       ser_load;
  logic       ser_shift;
  logic [1:0] mux_sel;
  logic       busy;
  tx_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  // {ser_load, ser_shift, busy, mux_sel}
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .RST        (RST),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .ser_load   (ser_load),
    .ser_shift  (ser_shift),
    .mux_sel    (mux_sel),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  function automatic int frame_len(input logic par);
    int n;
    n = W + 2 + (par ? 1 : 0);
`ifdef UART_TX_STOP2_EN
    n = n + 1;
`endif
    return n;
  endfunction

  task automatic exp_idle(input logic dv);
    exp_q.push_back({dv, 1'b0, 1'b0, MUX_STOP});
  endtask

  task automatic exp_frame(input logic par);
    exp_q.push_back({1'b0, 1'b0, 1'b1, MUX_START});
    for (int i = 0; i < W; i++) exp_q.push_back({1'b0, 1'b1, 1'b1, MUX_DATA});
    if (par) exp_q.push_back({1'b0, 1'b0, 1'b1, MUX_PAR});
    exp_q.push_back({1'b0, 1'b0, 1'b1, MUX_STOP});
`ifdef UART_TX_STOP2_EN
    exp_q.push_back({1'b0, 1'b0, 1'b1, MUX_STOP});
`endif
  endtask

  task automatic tick(input logic dv, input logic par, input logic rst, input string tag);
    logic [4:0] obs;
    logic [4:0] exp_v;
    @(posedge clk);
    #1;
    RST        = rst;
    Data_Valid = dv;
    PAR_EN     = par;
    @(negedge clk);
    obs = {ser_load, ser_shift, busy, mux_sel};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s no expected entry, observed %b", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s observed %b expected %b", tag, obs, exp_v);
      end
    end
  endtask

  task automatic check_state(input tx_state_e want, input string tag);
    checks++;
    assert (dbg_state === want)
    else begin
      errors++;
      $error("FAIL %s state observed %0d expected %0d", tag, dbg_state, want);
    end
  endtask

  initial begin
    RST        = 1'b0;
    Data_Valid = 1'b1;
    PAR_EN     = 1'b1;

    // Reset holds outputs idle even with a request present
    exp_idle(1'b0);
    tick(1'b1, 1'b1, 1'b0, "reset_dv");
    check_state(ST_IDLE, "reset_state");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b0, "reset_idle");

    // Request on the first edge after reset release, no parity
    exp_idle(1'b1);
    exp_frame(1'b0);
    tick(1'b1, 1'b0, 1'b1, "first_edge");
    for (int i = 0; i < frame_len(1'b0); i++) tick(1'b0, 1'b0, 1'b1, "frame_nopar");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b1, "idle_after_nopar");

    // Parity frame, PAR_EN dropped right after acceptance
    exp_idle(1'b1);
    exp_frame(1'b1);
    tick(1'b1, 1'b1, 1'b1, "par_accept");
    for (int i = 0; i < frame_len(1'b1); i++) tick(1'b0, 1'b0, 1'b1, "frame_par");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b1, "idle_after_par");

    // Data_Valid held for 30 cycles: loads at cycles 0, 11, 22
    for (int f = 0; f < 3; f++) begin
      exp_idle(1'b1);
      exp_frame(1'b0);
    end
    for (int i = 0; i < 3 * (frame_len(1'b0) + 1); i++)
      tick((i < 30) ? 1'b1 : 1'b0, 1'b0, 1'b1, "hold_dv");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b1, "idle_after_hold");

    // PAR_EN toggling mid-frame must not change the latched choice
    exp_idle(1'b1);
    exp_frame(1'b1);
    tick(1'b1, 1'b1, 1'b1, "toggle_par_accept");
    for (int i = 0; i < frame_len(1'b1); i++) tick(1'b0, i[0], 1'b1, "toggle_par1");
    exp_idle(1'b1);
    exp_frame(1'b0);
    tick(1'b1, 1'b0, 1'b1, "toggle_nopar_accept");
    for (int i = 0; i < frame_len(1'b0); i++) tick(1'b0, ~i[0], 1'b1, "toggle_par0");

    // Back-to-back frames with random requests ignored while busy
    exp_idle(1'b1);
    exp_frame(1'b1);
    tick(1'b1, 1'b1, 1'b1, "b2b_accept");
    for (int i = 0; i < frame_len(1'b1); i++)
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, "b2b_busy");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b1, "idle_after_b2b");

    // Reset on the 4th DATA cycle aborts at once; next request gets a full frame
    exp_idle(1'b1);
    exp_frame(1'b0);
    tick(1'b1, 1'b0, 1'b1, "abort_accept");
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b1, "abort_pre");
    exp_q.delete();
    exp_idle(1'b0);
    tick(1'b1, 1'b1, 1'b0, "abort_rst");
    check_state(ST_IDLE, "abort_state");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b1, "abort_release");
    exp_idle(1'b1);
    exp_frame(1'b0);
    tick(1'b1, 1'b0, 1'b1, "restart_accept");
    for (int i = 0; i < frame_len(1'b0); i++) tick(1'b0, 1'b0, 1'b1, "restart_frame");
    exp_idle(1'b0);
    tick(1'b0, 1'b0, 1'b1, "idle_final");
    check_state(ST_IDLE, "final_state");

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expected observed %0d entries expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving the number of data bits per frame.
REQ-002 The module SHALL have input clk, 1 bit, the single clock; all logic on its rising edge.
REQ-003 The module SHALL have input RST, 1 bit, asynchronous active-low reset.
REQ-004 The module SHALL have input Data_Valid, 1 bit, a request to send the word present on the datapath.
REQ-005 The module SHALL have input PAR_EN, 1 bit; 1 inserts a parity bit after the data bits.
REQ-006 The module SHALL have output ser_load, 1 bit, a one-cycle load strobe to the serializer and parity calculator.
REQ-007 The module SHALL have output ser_shift, 1 bit, the serializer advance strobe.
REQ-008 The module SHALL have output mux_sel, 2 bits, the line mux select: 00 start(0), 01 stop/idle(1), 10 serial data, 11 parity bit.
REQ-009 The module SHALL have output busy, 1 bit, high while a frame is in progress.

Function
REQ-010 The module SHALL implement the states IDLE, START, DATA, PARITY and STOP.
REQ-011 In IDLE, ser_load SHALL equal Data_Valid (combinational), and the next state SHALL be START when Data_Valid=1.
REQ-012 On acceptance, PAR_EN SHALL be latched; the latched value governs the whole frame, and later PAR_EN changes SHALL NOT affect it.
REQ-013 START SHALL last exactly 1 cycle and be followed by DATA.
REQ-014 DATA SHALL last exactly DATA_WIDTH cycles, counted by an internal counter of width $clog2(DATA_WIDTH) that is cleared on entry.
REQ-015 ser_shift SHALL be 1 in every DATA cycle and 0 in all other states.
REQ-016 On the last DATA cycle (count = DATA_WIDTH-1), the next state SHALL be PARITY if the latched PAR_EN=1, else STOP.
REQ-017 PARITY SHALL last 1 cycle and be followed by STOP.
REQ-018 STOP SHALL last 1 cycle and be followed by IDLE.
REQ-019 mux_sel SHALL be a Moore output of state: IDLE 01, START 00, DATA 10, PARITY 11, STOP 01.
REQ-020 busy SHALL be registered: 0 in IDLE and 1 in START, DATA, PARITY and STOP.
REQ-021 busy SHALL rise the cycle after acceptance and fall on the cycle IDLE is re-entered.
REQ-022 Data_Valid while busy=1 SHALL be ignored: no ser_load, and no effect on state or count.
REQ-023 Frame length SHALL be DATA_WIDTH+2 cycles, plus 1 with parity, plus 1 under REQ-029.
REQ-024 Data_Valid=1 on the cycle IDLE is re-entered SHALL be accepted normally, giving back-to-back frames with 1 idle cycle between them.
REQ-025 Unreachable state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-026 When RST=0, the module SHALL immediately force state IDLE, count 0, latched PAR_EN 0, busy 0, ser_shift 0, ser_load 0 and mux_sel 01.
REQ-027 A reset mid-frame SHALL abort the frame with no further strobes, and the line SHALL return to idle-high at once.
REQ-028 After RST deasserts, a Data_Valid on the first rising edge SHALL be accepted.

Configuration
REQ-029 With macro UART_TX_STOP2_EN defined, STOP SHALL last 2 cycles, tracked by a 1-bit stop counter, with mux_sel=01 in both cycles.
REQ-030 Without UART_TX_STOP2_EN, STOP SHALL last 1 cycle and no stop counter SHALL exist.

Structure
REQ-031 The state enum, the mux_sel encodings (MUX_START, MUX_STOP, MUX_DATA, MUX_PAR) and the default DATA_WIDTH SHALL live in shared package uart_tx_pkg, also used by the mux.
REQ-032 The block SHALL have no sub-module; the bit counter and FSM SHALL be inline.

Verification
REQ-033 Scenario: DATA_WIDTH=8, PAR_EN=0, one Data_Valid pulse -> ser_load 1 cycle; mux_sel 00 then 10 x8 then 01; busy high 10 cycles; ser_shift high 8 cycles.
REQ-034 Scenario: PAR_EN=1 -> mux_sel 00, 10 x8, 11, 01; busy high 11 cycles.
REQ-035 Scenario: Data_Valid held high for 30 cycles, PAR_EN=0 -> ser_load pulses exactly at cycles 0, 11 and 22, with no pulse while busy=1.
REQ-036 Scenario: PAR_EN toggled during DATA on a PAR_EN=1 frame -> PARITY is still visited.
REQ-037 Scenario: RST pulsed low at the 4th DATA cycle -> busy=0, mux_sel=01 and ser_shift=0 within the same cycle, and the next Data_Valid starts a full frame.
REQ-038 Scenario: build with UART_TX_STOP2_EN, PAR_EN=1 -> mux_sel=01 for 2 cycles after parity, and busy high 12 cycles.
